// File: rtl/mul17_pp_feeder.sv
// mul17_pp_feeder: operand intake, serial partial-product feeder and result
// capture for the 17x17 shift_register/compressor harness.
// Optional build macro: MUL17_SELFCHECK_EN adds a registered reference product,
// a live mismatch flag and a 16-bit saturating mismatch counter (err_cnt).
module mul17_pp_feeder #(
  parameter int WIDTH    = 17,
  parameter int COMP_LAT = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-2:0]   src_bits,
  input  logic [2*WIDTH:0]     dst_bits,
  output logic                 out_valid,
  output logic [2*WIDTH:0]     product,
  output logic                 mismatch
);

  localparam int NCOL = 2*WIDTH-1;
  localparam int PW   = 2*WIDTH+1;
  localparam int TW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CW   = (COMP_LAT > 1) ? $clog2(COMP_LAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_WAIT  = 2'd2,
    S_CAP   = 2'd3
  } state_t;

  state_t            state_r;
  logic [TW-1:0]     t_r;
  logic [CW-1:0]     wait_r;
  logic [WIDTH-1:0]  a_l_r;
  logic [WIDTH-1:0]  b_l_r;
  logic              in_ready_r;
  logic              out_valid_r;
  logic [PW-1:0]     product_r;
  logic [NCOL-1:0]   src_bits_s;

  // Column emitters: each column K has a fixed emission schedule over the
  // WIDTH shift cycles. It stays silent for the first WIDTH-h_K cycles, then
  // emits its h_K partial products so they end up exactly filling its
  // h_K-deep register. The schedule is built from constant indices only.
  genvar k, tt;
  generate
    for (k = 0; k < NCOL; k++) begin : g_col
      localparam int H   = ((k + 1) < (NCOL - k)) ? (k + 1) : (NCOL - k);
      localparam int I0  = ((k - WIDTH + 1) > 0) ? (k - WIDTH + 1) : 0;
      localparam int OFF = WIDTH - H;
      logic [WIDTH-1:0] emit_s;
      for (tt = 0; tt < WIDTH; tt++) begin : g_t
        if (tt >= OFF) begin : g_pp
          assign emit_s[tt] = a_l_r[I0 + tt - OFF] & b_l_r[k - I0 - tt + OFF];
        end else begin : g_zero
          assign emit_s[tt] = 1'b0;
        end
      end
      assign src_bits_s[k] = (state_r == S_SHIFT) ? emit_s[t_r] : 1'b0;
    end
  endgenerate

  assign src_bits  = src_bits_s;
  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign product   = product_r;

  // Control FSM: operand latch, shift-cycle count, settle wait and result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= S_IDLE;
      t_r         <= '0;
      wait_r      <= '0;
      a_l_r       <= '0;
      b_l_r       <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      product_r   <= '0;
    end else begin
      out_valid_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (in_valid) begin
            a_l_r      <= a;
            b_l_r      <= b;
            t_r        <= '0;
            in_ready_r <= 1'b0;
            state_r    <= S_SHIFT;
          end else begin
            in_ready_r <= 1'b1;
          end
        end
        S_SHIFT: begin
          if (t_r == TW'(WIDTH - 1)) begin
            wait_r  <= '0;
            state_r <= (COMP_LAT > 0) ? S_WAIT : S_CAP;
          end else begin
            t_r <= t_r + TW'(1);
          end
        end
        S_WAIT: begin
          if (wait_r == CW'(COMP_LAT - 1)) begin
            state_r <= S_CAP;
          end else begin
            wait_r <= wait_r + CW'(1);
          end
        end
        S_CAP: begin
          product_r   <= dst_bits;
          out_valid_r <= 1'b1;
          in_ready_r  <= 1'b1;
          state_r     <= S_IDLE;
        end
        default: begin
          in_ready_r <= 1'b1;
          state_r    <= S_IDLE;
        end
      endcase
    end
  end

`ifdef MUL17_SELFCHECK_EN
  // Zero-extended reference product of the latched operands.
  function automatic logic [PW-1:0] ref_product(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
    return PW'(x) * PW'(y);
  endfunction

  logic [PW-1:0] ref_r;
  logic          mismatch_r;
  logic [15:0]   err_cnt;
  logic          diff_s;

  assign diff_s   = (dst_bits != ref_r);
  assign mismatch = mismatch_r;

  // Reference product register; operands are stable long before capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_r <= '0;
    end else begin
      ref_r <= ref_product(a_l_r, b_l_r);
    end
  end

  // Compare the captured columns against the reference and count failures.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mismatch_r <= 1'b0;
      err_cnt    <= 16'd0;
    end else if (state_r == S_CAP) begin
      mismatch_r <= diff_s;
      if (diff_s && (err_cnt != 16'hFFFF)) begin
        err_cnt <= err_cnt + 16'd1;
      end else begin
        err_cnt <= err_cnt;
      end
    end else begin
      mismatch_r <= mismatch_r;
      err_cnt    <= err_cnt;
    end
  end
`else
  assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_mul17_pp_feeder.sv
// tb_mul17_pp_feeder: randomized and directed checks of mul17_pp_feeder.
// Two instances: dut0 with a combinational compressor (COMP_LAT=0) and dut1
// with a two-stage pipelined compressor (COMP_LAT=2). The harness around each
// is modelled as per-column shift registers whose bit counts are summed with
// column weights; expected products are plain a*b.
module tb_mul17_pp_feeder;

  localparam int W    = 17;
  localparam int NCOL = 2*W-1;
  localparam int PW   = 2*W+1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [1:0]        in_valid_v;
  logic [1:0]        in_ready_v;
  logic [1:0]        out_valid_v;
  logic [1:0]        mismatch_v;
  logic [W-1:0]      a_v       [2];
  logic [W-1:0]      b_v       [2];
  logic [NCOL-1:0]   src_v     [2];
  logic [PW-1:0]     dst_v     [2];
  logic [PW-1:0]     product_v [2];

  int n_vec = 0;
  int n_err = 0;

  mul17_pp_feeder #(.WIDTH(W), .COMP_LAT(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .a(a_v[0]), .b(b_v[0]), .src_bits(src_v[0]), .dst_bits(dst_v[0]),
    .out_valid(out_valid_v[0]), .product(product_v[0]), .mismatch(mismatch_v[0])
  );

  mul17_pp_feeder #(.WIDTH(W), .COMP_LAT(2)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .a(a_v[1]), .b(b_v[1]), .src_bits(src_v[1]), .dst_bits(dst_v[1]),
    .out_valid(out_valid_v[1]), .product(product_v[1]), .mismatch(mismatch_v[1])
  );

  // ---------------- harness model ----------------
  logic [W-1:0]  sr [2][NCOL];
  logic          seeded = 1'b0;
  logic          stuck0 = 1'b0;
  logic [PW-1:0] comb_s [2];
  logic [PW-1:0] pipe1_r, pipe2_r;

  function automatic int col_h(input int k);
    return ((k + 1) < (NCOL - k)) ? (k + 1) : (NCOL - k);
  endfunction

  function automatic logic [W-1:0] colmask(input int k);
    return W'((64'd1 << col_h(k)) - 64'd1);
  endfunction

  // Column shift registers (no reset, start with garbage) and compressor pipe.
  always @(posedge clk) begin
    if (!seeded) begin
      for (int i = 0; i < 2; i++)
        for (int k = 0; k < NCOL; k++)
          sr[i][k] <= W'($urandom);
      seeded <= 1'b1;
    end else begin
      for (int i = 0; i < 2; i++)
        for (int k = 0; k < NCOL; k++)
          sr[i][k] <= {sr[i][k][W-2:0], src_v[i][k]};
    end
    pipe1_r <= comb_s[1];
    pipe2_r <= pipe1_r;
  end

  // Compressor: weighted sum of the ones held in each column register.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      comb_s[i] = '0;
      for (int k = 0; k < NCOL; k++)
        comb_s[i] = comb_s[i] + (PW'($countones(sr[i][k] & colmask(k))) << k);
    end
  end

  assign dst_v[0] = comb_s[0] | {{(PW-1){1'b0}}, stuck0};
  assign dst_v[1] = pipe2_r;

  // ---------------- stimulus helper ----------------
  logic [NCOL-1:0] trace [64];

  // Offer one pair, then wait (bounded) for out_valid; lat counts edges after accept.
  task automatic do_op(input int inst, input logic [W-1:0] av, input logic [W-1:0] bv,
                       output logic [PW-1:0] prod, output logic mm, output int lat);
    int guard;
    @(negedge clk);
    guard = 0;
    while (!in_ready_v[inst] && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    in_valid_v[inst] = 1'b1;
    a_v[inst] = av;
    b_v[inst] = bv;
    @(negedge clk);
    in_valid_v[inst] = 1'b0;
    a_v[inst] = W'($urandom);
    b_v[inst] = W'($urandom);
    lat = 0;
    trace[0] = src_v[inst];
    while (!out_valid_v[inst] && lat < 60) begin
      @(negedge clk);
      lat++;
      if (lat < 64) trace[lat] = src_v[inst];
    end
    prod = product_v[inst];
    mm   = mismatch_v[inst];
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    in_valid_v = 2'b00;
    for (int i = 0; i < 2; i++) begin
      a_v[i] = '0;
      b_v[i] = '0;
    end
    repeat (3) @(negedge clk);
    n_vec++;
    if (in_ready_v !== 2'b11) begin
      n_err++; $display("FAIL reset_in_ready: got %b expected 11", in_ready_v);
    end
    n_vec++;
    if (out_valid_v !== 2'b00 || mismatch_v !== 2'b00) begin
      n_err++; $display("FAIL reset_flags: out_valid %b mismatch %b expected 00 00", out_valid_v, mismatch_v);
    end
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if (product_v[i] !== '0 || src_v[i] !== '0) begin
        n_err++; $display("FAIL reset_data%0d: product %h src %h expected 0 0", i, product_v[i], src_v[i]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ones();
    logic [PW-1:0] p; logic mm; int lat;
    do_op(0, W'(1), W'(1), p, mm, lat);
    n_vec++;
    if (p !== PW'(1) || mm !== 1'b0 || lat != 18) begin
      n_err++; $display("FAIL ones_result: product %h mm %b lat %0d expected 1 0 18", p, mm, lat);
    end
    for (int c = 0; c <= 18; c++) begin
      logic [NCOL-1:0] e;
      e = (c == 16) ? NCOL'(1) : '0;
      n_vec++;
      if (trace[c] !== e) begin
        n_err++; $display("FAIL ones_src_t%0d: got %h expected %h", c, trace[c], e);
      end
    end
  endtask

  task automatic test_max();
    logic [PW-1:0] p; logic mm; int lat; logic [PW-1:0] e;
    e = PW'(17'h1FFFF) * PW'(17'h1FFFF);
    do_op(0, 17'h1FFFF, 17'h1FFFF, p, mm, lat);
    n_vec++;
    if (p !== e || mm !== 1'b0 || lat != 18) begin
      n_err++; $display("FAIL max_result: product %h mm %b lat %0d expected %h 0 18", p, mm, lat, e);
    end
  endtask

  task automatic test_back_to_back();
    int cnt;
    logic [PW-1:0] e1, e2;
    e1 = PW'(17'h12345) * PW'(17'h0ABCD);
    e2 = PW'(17'h1FFFF) * PW'(17'h00002);
    @(negedge clk);
    in_valid_v[0] = 1'b1; a_v[0] = 17'h12345; b_v[0] = 17'h0ABCD;
    @(negedge clk);
    a_v[0] = 17'h1FFFF; b_v[0] = 17'h00002;
    cnt = 0;
    while (!out_valid_v[0] && cnt < 60) begin
      @(negedge clk);
      cnt++;
    end
    n_vec++;
    if (product_v[0] !== e1 || cnt != 18 || in_ready_v[0] !== 1'b1) begin
      n_err++; $display("FAIL b2b_first: product %h lat %0d ready %b expected %h 18 1", product_v[0], cnt, in_ready_v[0], e1);
    end
    @(negedge clk);
    in_valid_v[0] = 1'b0;
    cnt = 1;
    while (!out_valid_v[0] && cnt < 60) begin
      @(negedge clk);
      cnt++;
    end
    n_vec++;
    if (product_v[0] !== e2 || cnt != W + 2) begin
      n_err++; $display("FAIL b2b_second: product %h pulse gap %0d expected %h %0d", product_v[0], cnt, e2, W + 2);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    logic [PW-1:0] p; logic mm; int lat;
    @(negedge clk);
    in_valid_v[0] = 1'b1; a_v[0] = 17'h1FFFF; b_v[0] = 17'h1FFFF;
    @(negedge clk);
    in_valid_v[0] = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    n_vec++;
    if (in_ready_v[0] !== 1'b1 || src_v[0] !== '0 || out_valid_v[0] !== 1'b0) begin
      n_err++; $display("FAIL midrst_abort: ready %b src %h out_valid %b expected 1 0 0", in_ready_v[0], src_v[0], out_valid_v[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (out_valid_v[0]) pulses++;
    end
    n_vec++;
    if (pulses != 0) begin
      n_err++; $display("FAIL midrst_no_pulse: got %0d pulses expected 0", pulses);
    end
    do_op(0, W'(3), W'(5), p, mm, lat);
    n_vec++;
    if (p !== PW'(15) || lat != 18) begin
      n_err++; $display("FAIL midrst_restart: product %h lat %0d expected f 18", p, lat);
    end
  endtask

  task automatic test_comp_lat2();
    logic [PW-1:0] p; logic mm; int lat; logic [PW-1:0] e;
    e = PW'(17'h10000) * PW'(17'h10000);
    do_op(1, 17'h10000, 17'h10000, p, mm, lat);
    n_vec++;
    if (p !== e || mm !== 1'b0 || lat != 20) begin
      n_err++; $display("FAIL lat2_result: product %h mm %b lat %0d expected %h 0 20", p, mm, lat, e);
    end
  endtask

  task automatic test_random();
    logic [PW-1:0] p; logic mm; int lat; logic [PW-1:0] e;
    logic [W-1:0] av, bv;
    int inst, el;
    for (int n = 0; n < 12; n++) begin
      inst = n % 2;
      av = W'($urandom);
      bv = W'($urandom);
      if (n == 2) av = '1;
      if (n == 3) bv = '0;
      e  = PW'(av) * PW'(bv);
      el = (inst == 0) ? 18 : 20;
      do_op(inst, av, bv, p, mm, lat);
      n_vec++;
      if (p !== e || mm !== 1'b0 || lat != el) begin
        n_err++; $display("FAIL random_%0d: inst %0d a %h b %h product %h mm %b lat %0d expected %h 0 %0d",
                          n, inst, av, bv, p, mm, lat, e, el);
      end
    end
  endtask

`ifdef MUL17_SELFCHECK_EN
  task automatic test_selfcheck();
    logic [PW-1:0] p; logic mm; int lat; logic [PW-1:0] e;
    n_vec++;
    if (dut0.err_cnt !== 16'd0) begin
      n_err++; $display("FAIL selfcheck_cnt_before: got %0d expected 0", dut0.err_cnt);
    end
    e = (PW'(2) * PW'(2)) | PW'(1);
    stuck0 = 1'b1;
    do_op(0, W'(2), W'(2), p, mm, lat);
    stuck0 = 1'b0;
    n_vec++;
    if (p !== e || mm !== 1'b1) begin
      n_err++; $display("FAIL selfcheck_flag: product %h mm %b expected %h 1", p, mm, e);
    end
    n_vec++;
    if (dut0.err_cnt !== 16'd1) begin
      n_err++; $display("FAIL selfcheck_cnt_after: got %0d expected 1", dut0.err_cnt);
    end
  endtask
`endif

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ones();
    test_max();
    test_back_to_back();
    test_reset_mid();
    test_comp_lat2();
    test_random();
`ifdef MUL17_SELFCHECK_EN
    test_selfcheck();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
